// File: rtl/flappy_game_ctrl_pkg.sv
// flappy_pkg: types and constants shared by the game controller, its
// hit-check sub-module and the port interface.
//   game_state_t      : READY / PLAY / DYING / OVER encoding (2 bits)
//   KEY_W / KEY_R     : start/flap and restart USB keycodes
//   X_MAX / Y_MAX     : last visible column / row
//   *_DEF             : default pipe width, gap half-height, floor row
package flappy_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_R = 8'h15;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  localparam int PIPE_W_DEF   = 40;
  localparam int GAP_HALF_DEF = 50;
  localparam int FLOOR_Y_DEF  = 440;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// flappy_game_ctrl_if: per-frame game data bundle.
//   master : drives keycode, bird and pipe positions; observes results
//   slave  : the controller; consumes positions, produces score/state
//   keycode (8), BirdX/BirdY/BirdS (10), Pipe{0,1,2}X/Y (10)
//   score/best_score (27), game_state (2), run (1), hit (1)
interface flappy_game_ctrl_if;
  import flappy_pkg::*;

  logic [7:0]  keycode;
  logic [9:0]  BirdX;
  logic [9:0]  BirdY;
  logic [9:0]  BirdS;
  logic [9:0]  Pipe0X;
  logic [9:0]  Pipe1X;
  logic [9:0]  Pipe2X;
  logic [9:0]  Pipe0Y;
  logic [9:0]  Pipe1Y;
  logic [9:0]  Pipe2Y;
  logic [26:0] score;
  logic [26:0] best_score;
  game_state_t game_state;
  logic        run;
  logic        hit;

  modport master (
    output keycode, BirdX, BirdY, BirdS,
    output Pipe0X, Pipe1X, Pipe2X, Pipe0Y, Pipe1Y, Pipe2Y,
    input  score, best_score, game_state, run, hit
  );

  modport slave (
    input  keycode, BirdX, BirdY, BirdS,
    input  Pipe0X, Pipe1X, Pipe2X, Pipe0Y, Pipe1Y, Pipe2Y,
    output score, best_score, game_state, run, hit
  );

endinterface

// File: rtl/flappy_game_ctrl_pipe_hit_check.sv
// pipe_hit_check: combinational collision / pass test for one pipe.
//   bird_x, bird_y, bird_s : bird centre and half-size
//   pipe_x, pipe_y         : pipe left edge and gap centre
//   prev_x                 : pipe left edge registered last frame
//   collide                : bird overlaps the column and is outside the gap
//   pass                   : pipe left edge crossed bird centre this frame
module pipe_hit_check
  import flappy_pkg::*;
#(
  parameter int PIPE_W   = PIPE_W_DEF,
  parameter int GAP_HALF = GAP_HALF_DEF
) (
  input  logic [9:0] bird_x,
  input  logic [9:0] bird_y,
  input  logic [9:0] bird_s,
  input  logic [9:0] pipe_x,
  input  logic [9:0] pipe_y,
  input  logic [9:0] prev_x,
  output logic       collide,
  output logic       pass
);

  localparam logic [10:0] PIPE_W_M1 = 11'(PIPE_W - 1);
  localparam logic [10:0] GAP_H11   = 11'(GAP_HALF);
  localparam logic [9:0]  GAP_H10   = 10'(GAP_HALF);
  localparam logic [9:0]  X_MAX10   = 10'(X_MAX);

  // Edges above the top of the screen clamp to row/column 0.
  function automatic logic [10:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
    if (a >= b) return {1'b0, a - b};
    else        return 11'd0;
  endfunction

  logic [10:0] bird_l, bird_r, bird_t, bird_b;
  logic [10:0] pipe_r, gap_t, gap_b;
  logic        h_overlap, out_of_gap;

  always_comb begin
    bird_r     = {1'b0, bird_x} + {1'b0, bird_s};
    bird_l     = sat_sub(bird_x, bird_s);
    bird_b     = {1'b0, bird_y} + {1'b0, bird_s};
    bird_t     = sat_sub(bird_y, bird_s);
    pipe_r     = {1'b0, pipe_x} + PIPE_W_M1;
    gap_b      = {1'b0, pipe_y} + GAP_H11;
    gap_t      = sat_sub(pipe_y, GAP_H10);
    h_overlap  = (bird_r >= {1'b0, pipe_x}) && (bird_l <= pipe_r);
    out_of_gap = (bird_t < gap_t) || (bird_b > gap_b);
    collide    = h_overlap && out_of_gap;
    // A pipe sitting at the right edge has just respawned; never a pass.
    pass       = (prev_x > bird_x) && (pipe_x <= bird_x) && (pipe_x < X_MAX10);
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game-state and scoring controller.
//   frame_clk : one rising edge per video frame
//   Reset_n   : asynchronous active-low reset
//   bus       : flappy_game_ctrl_if.slave -- keycode, bird/pipe positions in;
//               score, best_score, game_state, run, hit out (all registered)
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int PIPE_W     = PIPE_W_DEF,
  parameter int GAP_HALF   = GAP_HALF_DEF,
  parameter int FLOOR_Y    = FLOOR_Y_DEF,
  parameter int DIE_FRAMES = 60
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  flappy_game_ctrl_if.slave    bus
);

  localparam logic [26:0] SCORE_MAX = 27'h7FFFFFF;
  localparam logic [9:0]  X_RESET   = 10'(X_MAX);

  game_state_t state;
  logic [26:0] score, best_score;
  logic        run, hit;
  logic [6:0]  die_cnt;
  logic [9:0]  prev_x [3];
  logic [9:0]  pipe_x [3];
  logic [9:0]  pipe_y [3];
  logic [2:0]  collide, pass;
  logic [1:0]  n_pass;
  logic        floor_hit;

  function automatic logic [26:0] sat_add(input logic [26:0] a, input logic [1:0] n);
    logic [27:0] s;
    s = {1'b0, a} + {26'd0, n};
    if (s[27]) return SCORE_MAX;
    else       return s[26:0];
  endfunction

  assign pipe_x[0] = bus.Pipe0X;
  assign pipe_x[1] = bus.Pipe1X;
  assign pipe_x[2] = bus.Pipe2X;
  assign pipe_y[0] = bus.Pipe0Y;
  assign pipe_y[1] = bus.Pipe1Y;
  assign pipe_y[2] = bus.Pipe2Y;

  for (genvar i = 0; i < 3; i++) begin : g_pipe
    pipe_hit_check #(
      .PIPE_W   (PIPE_W),
      .GAP_HALF (GAP_HALF)
    ) u_check (
      .bird_x  (bus.BirdX),
      .bird_y  (bus.BirdY),
      .bird_s  (bus.BirdS),
      .pipe_x  (pipe_x[i]),
      .pipe_y  (pipe_y[i]),
      .prev_x  (prev_x[i]),
      .collide (collide[i]),
      .pass    (pass[i])
    );
  end

  always_comb begin
    n_pass    = {1'b0, pass[0]} + {1'b0, pass[1]} + {1'b0, pass[2]};
    floor_hit = ({1'b0, bus.BirdY} + {1'b0, bus.BirdS}) >= 11'(FLOOR_Y);
  end

  // Frame boundary: state, counters and scores advance once per frame.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= READY;
      score      <= '0;
      best_score <= '0;
      run        <= 1'b0;
      hit        <= 1'b0;
      die_cnt    <= '0;
      for (int i = 0; i < 3; i++) prev_x[i] <= X_RESET;
    end else begin
      for (int i = 0; i < 3; i++) prev_x[i] <= pipe_x[i];
      hit <= 1'b0;
      case (state)
        READY: begin
          if (bus.keycode == KEY_W) begin
            state <= PLAY;
            score <= '0;
            run   <= 1'b1;
          end
        end
        PLAY: begin
          // Passes in the collision frame still count.
          score <= sat_add(score, n_pass);
          if ((|collide) || floor_hit) begin
            state   <= DYING;
            run     <= 1'b0;
            hit     <= 1'b1;
            die_cnt <= 7'(DIE_FRAMES - 1);
          end
        end
        DYING: begin
          if (die_cnt == '0) begin
            state <= OVER;
            if (score > best_score) best_score <= score;
          end else begin
            die_cnt <= die_cnt - 7'd1;
          end
        end
        OVER: begin
          if (bus.keycode == KEY_R) state <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

  assign bus.score      = score;
  assign bus.best_score = best_score;
  assign bus.game_state = state;
  assign bus.run        = run;
  assign bus.hit        = hit;

endmodule
